imem_line_refill: RTL and testbench

- Upstream neighbour of the fetch stage's instruction cache.
- On a cache miss it reads one 128-bit line from a 32-bit-wide word memory, one word per transfer, and packs the words into a line.
- It delivers the line on line_out, which drives the fetch stage's mem_in, and pulses line_valid.
- It holds `stall` high while a refill is in progress, and a branch flush aborts the refill cleanly.

---
 rtl/imem_line_refill.sv | 93 +++++++++
 tb/tb_imem_line_refill.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_line_refill.sv
// imem_line_refill: refills one instruction-cache line word by word from a narrow memory
module imem_line_refill #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               miss_req,
  input  logic [ADDR_W-1:0]                  miss_addr,
  input  logic                               flush,
  output logic                               mem_rd_req,
  output logic [ADDR_W-1:0]                  mem_rd_addr,
  input  logic                               mem_rd_valid,
  input  logic [WORD_W-1:0]                  mem_rd_data,
  output logic [WORD_W*WORDS_PER_LINE-1:0]   line_out,
  output logic [ADDR_W-1:0]                  line_addr,
  output logic                               line_valid,
  output logic                               stall
);
  localparam int CNT_W  = $clog2(WORDS_PER_LINE);
  localparam int BYTE_W = $clog2(WORD_W/8);
  localparam int OFF_W  = CNT_W + BYTE_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS_PER_LINE-1);
  typedef enum logic [1:0] {IDLE, FILL, DONE, ABORT} state_t;
  state_t                                  state_q;
  logic [CNT_W-1:0]                        cnt_q;
  logic [CNT_W-1:0]                        cnt_d;
  logic [WORDS_PER_LINE-1:0][WORD_W-1:0]   line_q;
  logic [ADDR_W-1:0]                       base_q;
  logic [ADDR_W-1:0]                       addr_q;
  logic                                    req_q;
  logic                                    valid_q;
  logic                                    stall_q;
  logic                                    unused_ok;
  assign cnt_d       = cnt_q + 1'b1;
  assign unused_ok   = ^miss_addr[OFF_W-1:0];
  assign mem_rd_req  = req_q;
  assign mem_rd_addr = addr_q;
  assign line_out    = line_q;
  assign line_addr   = base_q;
  assign line_valid  = valid_q;
  assign stall       = stall_q;
  // word offset is spliced into the address so it never carries out of the line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: if (miss_req && !flush) begin
          state_q <= FILL;
          cnt_q   <= '0;
          base_q  <= {miss_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          addr_q  <= {miss_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          req_q   <= 1'b1;
          stall_q <= 1'b1;
        end
        FILL: if (mem_rd_valid && flush) begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          stall_q <= 1'b0;
        end else if (mem_rd_valid) begin
          line_q[cnt_q] <= mem_rd_data;
          cnt_q         <= cnt_d;
          addr_q        <= {base_q[ADDR_W-1:OFF_W], cnt_d, {BYTE_W{1'b0}}};
          if (cnt_q == LAST) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            stall_q <= 1'b0;
            valid_q <= 1'b1;
          end
        end else if (flush) begin
          state_q <= ABORT;
        end
        ABORT: if (mem_rd_valid) begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          stall_q <= 1'b0;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_line_refill.sv
// tb_imem_line_refill: directed vectors plus hand sequences for flush, reset and back-to-back refills
module tb_imem_line_refill;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         miss_req = 1'b0;
  logic [31:0]  miss_addr = '0;
  logic         flush = 1'b0;
  logic         mem_rd_req;
  logic [31:0]  mem_rd_addr;
  logic         mem_rd_valid = 1'b0;
  logic [31:0]  mem_rd_data = '0;
  logic [127:0] line_out;
  logic [31:0]  line_addr;
  logic         line_valid;
  logic         stall;
  int total = 0;
  int bad = 0;
  int stall_total = 0;
  int lv_total = 0;

  imem_line_refill dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr), .flush(flush),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_valid(mem_rd_valid),
    .mem_rd_data(mem_rd_data), .line_out(line_out), .line_addr(line_addr),
    .line_valid(line_valid), .stall(stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    stall_total <= stall_total + int'(stall);
    lv_total    <= lv_total + int'(line_valid);
  end

  typedef struct packed {
    logic [31:0]       addr;
    logic [31:0]       base;
    logic [3:0][31:0]  w;
    logic [3:0][1:0]   wt;
    logic [127:0]      line;
  } vec_t;
  vec_t vt [3];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // starts in FILL at a negedge; returns at the negedge after the last served word
  task automatic serve(input logic [31:0] base, input logic [3:0][31:0] w,
                       input logic [3:0][1:0] wt, input int n);
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < int'(wt[k]); j++) begin
        chk("req_wait", 128'(mem_rd_req), 128'(1));
        chk("addr_wait", 128'(mem_rd_addr), 128'(base + 32'(4*k)));
        mem_rd_valid = 1'b0;
        @(negedge clk);
      end
      chk("req", 128'(mem_rd_req), 128'(1));
      chk("addr", 128'(mem_rd_addr), 128'(base + 32'(4*k)));
      mem_rd_valid = 1'b1;
      mem_rd_data  = w[k];
      @(negedge clk);
      mem_rd_valid = 1'b0;
    end
  endtask

  task automatic refill(input vec_t v);
    int s0, l0, ws;
    s0 = stall_total;
    l0 = lv_total;
    ws = int'(v.wt[0]) + int'(v.wt[1]) + int'(v.wt[2]) + int'(v.wt[3]);
    miss_req  = 1'b1;
    miss_addr = v.addr;
    @(negedge clk);
    miss_req = 1'b0;
    serve(v.base, v.w, v.wt, 4);
    chk("line_valid", 128'(line_valid), 128'(1));
    chk("line_addr", 128'(line_addr), 128'(v.base));
    chk("line_out", line_out, v.line);
    chk("req_done", 128'(mem_rd_req), 128'(0));
    chk("stall_done", 128'(stall), 128'(0));
    @(negedge clk);
    chk("lv_pulses", 128'(lv_total - l0), 128'(1));
    chk("stall_cycles", 128'(stall_total - s0), 128'(4 + ws));
    chk("line_hold", line_out, v.line);
  endtask

  initial begin
    int l0, p1, p2, np, cyc;
    logic [31:0] a1, a2;
    logic [127:0] o1, o2;
    vt[0] = '{addr: 32'h0000_0014, base: 32'h0000_0010,
              w: {32'h0000_7C00, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF},
              wt: {2'd0, 2'd0, 2'd0, 2'd0},
              line: 128'h00007C00_FFFFFFFF_00000000_FFFFFFFF};
    vt[1] = '{addr: 32'h1234_567C, base: 32'h1234_5670,
              w: {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111},
              wt: {2'd2, 2'd3, 2'd0, 2'd1},
              line: 128'h44444444_33333333_22222222_11111111};
    vt[2] = '{addr: 32'hFFFF_FFFF, base: 32'hFFFF_FFF0,
              w: {32'h89AB_CDEF, 32'h0123_4567, 32'hCAFE_F00D, 32'hDEAD_BEEF},
              wt: {2'd2, 2'd2, 2'd2, 2'd2},
              line: 128'h89ABCDEF_01234567_CAFEF00D_DEADBEEF};
    // reset held with a pending miss
    miss_req  = 1'b1;
    miss_addr = 32'h0000_0044;
    repeat (10) @(negedge clk);
    chk("rst_req", 128'(mem_rd_req), 128'(0));
    chk("rst_addr", 128'(mem_rd_addr), 128'(0));
    chk("rst_line", line_out, 128'(0));
    chk("rst_laddr", 128'(line_addr), 128'(0));
    chk("rst_lv", 128'(line_valid), 128'(0));
    chk("rst_stall", 128'(stall), 128'(0));
    rst = 1'b1;
    @(negedge clk);
    miss_req = 1'b0;
    chk("post_rst_stall", 128'(stall), 128'(1));
    serve(32'h0000_0040, {32'hD, 32'hC, 32'hB, 32'hA}, '0, 4);
    chk("post_rst_lv", 128'(line_valid), 128'(1));
    chk("post_rst_line", line_out, 128'h0000000D_0000000C_0000000B_0000000A);
    @(negedge clk);
    for (int i = 0; i < 3; i++) refill(vt[i]);
    // flush coincident with miss wins
    miss_req = 1'b1;
    flush    = 1'b1;
    miss_addr = 32'h0000_0060;
    @(negedge clk);
    miss_req = 1'b0;
    flush    = 1'b0;
    chk("idle_flush_req", 128'(mem_rd_req), 128'(0));
    chk("idle_flush_stall", 128'(stall), 128'(0));
    // flush with a transfer pending: ABORT holds the request until valid
    l0 = lv_total;
    miss_req  = 1'b1;
    miss_addr = 32'h0000_0080;
    @(negedge clk);
    miss_req = 1'b0;
    serve(32'h0000_0080, {32'h4, 32'h3, 32'h2, 32'h1}, '0, 2);
    flush = 1'b1;
    @(negedge clk);
    chk("abort_req", 128'(mem_rd_req), 128'(1));
    chk("abort_addr", 128'(mem_rd_addr), 128'(32'h88));
    chk("abort_stall", 128'(stall), 128'(1));
    @(negedge clk);
    flush = 1'b0;
    chk("abort_req2", 128'(mem_rd_req), 128'(1));
    chk("abort_addr2", 128'(mem_rd_addr), 128'(32'h88));
    mem_rd_valid = 1'b1;
    mem_rd_data  = 32'hAAAA_AAAA;
    @(negedge clk);
    mem_rd_valid = 1'b0;
    chk("abort_end_req", 128'(mem_rd_req), 128'(0));
    chk("abort_end_stall", 128'(stall), 128'(0));
    @(negedge clk);
    chk("abort_no_lv", 128'(lv_total - l0), 128'(0));
    // flush in the same cycle as the third word's valid
    miss_req  = 1'b1;
    miss_addr = 32'h0000_00A8;
    @(negedge clk);
    miss_req = 1'b0;
    serve(32'h0000_00A0, {32'h4, 32'h3, 32'h2, 32'h1}, '0, 2);
    flush        = 1'b1;
    mem_rd_valid = 1'b1;
    mem_rd_data  = 32'hBBBB_BBBB;
    @(negedge clk);
    flush        = 1'b0;
    mem_rd_valid = 1'b0;
    chk("coinc_req", 128'(mem_rd_req), 128'(0));
    chk("coinc_stall", 128'(stall), 128'(0));
    repeat (2) @(negedge clk);
    chk("coinc_req_later", 128'(mem_rd_req), 128'(0));
    chk("coinc_no_lv", 128'(lv_total - l0), 128'(0));
    // asynchronous reset in the middle of a refill
    miss_req  = 1'b1;
    miss_addr = 32'h0000_00C0;
    @(negedge clk);
    miss_req = 1'b0;
    serve(32'h0000_00C0, {32'h4, 32'h3, 32'h2, 32'h1}, '0, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_req", 128'(mem_rd_req), 128'(0));
    chk("mid_rst_stall", 128'(stall), 128'(0));
    chk("mid_rst_line", line_out, 128'(0));
    chk("mid_rst_laddr", 128'(line_addr), 128'(0));
    @(negedge clk);
    rst = 1'b1;
    // back-to-back misses with a zero-wait memory returning ~address
    miss_req  = 1'b1;
    miss_addr = 32'h0000_0020;
    np = 0; p1 = 0; p2 = 0; a1 = '0; a2 = '0; o1 = '0; o2 = '0;
    for (cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (line_valid) begin
        np++;
        if (np == 1) begin
          p1 = cyc; a1 = line_addr; o1 = line_out; miss_addr = 32'h0000_0030;
        end else begin
          p2 = cyc; a2 = line_addr; o2 = line_out; miss_req = 1'b0;
        end
      end
      mem_rd_valid = mem_rd_req;
      mem_rd_data  = ~mem_rd_addr;
    end
    mem_rd_valid = 1'b0;
    chk("b2b_pulses", 128'(np), 128'(2));
    chk("b2b_gap_ge6", 128'(p2 - p1 >= 6), 128'(1));
    chk("b2b_addr1", 128'(a1), 128'(32'h20));
    chk("b2b_line1", o1, 128'hFFFFFFD3_FFFFFFD7_FFFFFFDB_FFFFFFDF);
    chk("b2b_addr2", 128'(a2), 128'(32'h30));
    chk("b2b_line2", o2, 128'hFFFFFFC3_FFFFFFC7_FFFFFFCB_FFFFFFCF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
